// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// ---------------------------------------------------------------------------
// AHB-Lite responder in front of a single-port synchronous SRAM macro.
// Writes complete with zero wait states. Reads take one wait state because the
// SRAM returns data the cycle after the access. Illegal transfers (oversize,
// misaligned, or beyond the top of the memory) get the two-cycle ERROR response.
//
// Ports
//   HCLK, HRESETn      bus clock, asynchronous active-low reset
//   HSEL .. HREADY     AHB-Lite slave-side inputs (HBURST is ignored)
//   HRDATA             read data; follows SRAM_DO in the second read cycle and
//                      holds the last read word otherwise
//   HREADYOUT, HRESP   this slave's ready and response
//   SRAM_CS/WE/BWE/A   registered SRAM control, driven for one cycle per access
//   SRAM_DI            SRAM write data, passed straight through from HWDATA
//   SRAM_DO            SRAM read data, valid the cycle after a CS read
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int MEM_WORDS = 16384
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          HSEL,
    input  logic [31:0]                   HADDR,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [2:0]                    HBURST,
    input  logic [31:0]                   HWDATA,
    input  logic                          HREADY,
    output logic [31:0]                   HRDATA,
    output logic                          HREADYOUT,
    output logic [1:0]                    HRESP,
    output logic                          SRAM_CS,
    output logic                          SRAM_WE,
    output logic [3:0]                    SRAM_BWE,
    output logic [$clog2(MEM_WORDS)-1:0]  SRAM_A,
    output logic [31:0]                   SRAM_DI,
    input  logic [31:0]                   SRAM_DO
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD1,
        ST_RD2,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic            hreadyout_q;
    logic [1:0]      hresp_q;
    logic            sram_cs_q;
    logic            sram_we_q;
    logic [3:0]      sram_bwe_q;
    logic [AW-1:0]   sram_a_q;
    logic [31:0]     rdata_q;

    logic            sample;
    logic            size_ok;
    logic            align_ok;
    logic            range_ok;
    logic            legal;
    logic [3:0]      lane;

    // Bursts are handled beat by beat and BUSY is treated like IDLE, so
    // HBURST and HTRANS[0] carry no information for this slave.
    logic            unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    // Address phase is taken only when the bus is ready and a NONSEQ/SEQ
    // transfer targets us. RD1 and ERR1 never look at it (see next-state).
    assign sample   = HSEL & HREADY & HTRANS[1];
    assign size_ok  = (HSIZE <= 3'b010);
    assign range_ok = ((HADDR >> (AW + 2)) == 32'd0);
    assign legal    = size_ok & align_ok & range_ok;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        align_ok = 1'b1;
        lane     = 4'b0000;
        unique case (HSIZE)
            3'b000: lane = 4'b0001 << HADDR[1:0];
            3'b001: begin
                align_ok = ~HADDR[0];
                lane     = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                align_ok = (HADDR[1:0] == 2'b00);
                lane     = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            // Wait-state cycles advance unconditionally; HREADY is low on the
            // bus, so no new address phase can be pending.
            ST_RD1:  state_d = ST_RD2;
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (sample) begin
                    if (!legal)      state_d = ST_ERR1;
                    else if (HWRITE) state_d = ST_WR;
                    else             state_d = ST_RD1;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            sram_cs_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_bwe_q  <= 4'b0000;
            sram_a_q    <= '0;
            rdata_q     <= 32'd0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every register
            // sees the pre-edge value of every other one.
            state_q     <= state_d;
            hreadyout_q <= !(state_d inside {ST_RD1, ST_ERR1});
            hresp_q     <= (state_d inside {ST_ERR1, ST_ERR2}) ? 2'b01 : 2'b00;
            sram_cs_q   <= (state_d inside {ST_WR, ST_RD1});
            sram_we_q   <= (state_d == ST_WR);
            sram_bwe_q  <= (state_d == ST_WR) ? lane : 4'b0000;
            if (state_d inside {ST_WR, ST_RD1}) begin
                sram_a_q <= HADDR[AW+1:2];
            end
            if (state_q == ST_RD2) begin
                rdata_q <= SRAM_DO;
            end
        end
    end

    // SRAM_DO is only valid during RD2, so it goes onto the bus combinationally
    // in that cycle and the captured copy is presented afterwards.
    assign HRDATA    = (state_q == ST_RD2) ? SRAM_DO : rdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign SRAM_CS   = sram_cs_q;
    assign SRAM_WE   = sram_we_q;
    assign SRAM_BWE  = sram_bwe_q;
    assign SRAM_A    = sram_a_q;
    assign SRAM_DI   = HWDATA;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
// ---------------------------------------------------------------------------
// Directed bench for ahb_sram_slave. A behavioural bus model predicts, cycle by
// cycle, which data phase the slave is in and what it must show; HREADY is
// driven from that prediction. A simple SRAM model sits on the memory port.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

    localparam int MW  = 1024;
    localparam int AWB = $clog2(MW);

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            HSEL;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [31:0]     HWDATA;
    logic            HREADY;
    logic [31:0]     HRDATA;
    logic            HREADYOUT;
    logic [1:0]      HRESP;
    logic            SRAM_CS;
    logic            SRAM_WE;
    logic [3:0]      SRAM_BWE;
    logic [AWB-1:0]  SRAM_A;
    logic [31:0]     SRAM_DI;
    logic [31:0]     SRAM_DO;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.MEM_WORDS(MW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .SRAM_CS(SRAM_CS),
        .SRAM_WE(SRAM_WE), .SRAM_BWE(SRAM_BWE), .SRAM_A(SRAM_A),
        .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    // ---------------- SRAM macro model ----------------
    logic [31:0] sram [MW];

    always @(posedge HCLK) begin
        if (SRAM_CS) begin
            if (SRAM_WE) begin
                for (int b = 0; b < 4; b++)
                    if (SRAM_BWE[b]) sram[SRAM_A][8*b +: 8] <= SRAM_DI[8*b +: 8];
            end else begin
                SRAM_DO <= sram[SRAM_A];
            end
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A_0000 | 32'(i);
    endfunction

    // ---------------- scoring ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // ---------------- bus model ----------------
    typedef enum int {K_IDLE, K_WR, K_RD1, K_RD2, K_ERR1, K_ERR2} kind_e;
    typedef struct {
        kind_e       kind;
        int          a;
        logic [3:0]  bwe;
        logic [31:0] wdata;
        logic [31:0] hrdata;
    } exp_t;

    exp_t        pend[$];
    exp_t        exp_cur;
    logic [31:0] ref_mem [MW];
    logic [31:0] last_rd;
    logic [31:0] stim_wdata;
    int          dp_cycles;

    function automatic exp_t mk(input kind_e k, input int a, input logic [3:0] bwe,
                                input logic [31:0] wd);
        exp_t e;
        e.kind = k; e.a = a; e.bwe = bwe; e.wdata = wd; e.hrdata = 32'd0;
        return e;
    endfunction

    // One call per rising edge, just after it: retire the finished data phase,
    // accept the address phase presented before the edge, pick the new phase.
    function automatic void model_update();
        int   nbytes;
        int   mask;
        logic legal;
        if (!HRESETn) begin
            pend.delete();
            exp_cur = mk(K_IDLE, 0, 4'b0, 32'd0);
            last_rd = 32'd0;
            HREADY  = 1'b1;
            return;
        end
        if (exp_cur.kind == K_WR)
            for (int b = 0; b < 4; b++)
                if (exp_cur.bwe[b]) ref_mem[exp_cur.a][8*b +: 8] = exp_cur.wdata[8*b +: 8];
        if (HREADY && HSEL && HTRANS[1]) begin
            nbytes = 1 << HSIZE;
            legal  = (HSIZE <= 3'd2) && (HADDR % nbytes == 0) && (HADDR < 32'(MW * 4));
            if (!legal) begin
                pend.push_back(mk(K_ERR1, 0, 4'b0, 32'd0));
                pend.push_back(mk(K_ERR2, 0, 4'b0, 32'd0));
            end else if (HWRITE) begin
                mask = ((1 << nbytes) - 1) << (HADDR % 4);
                pend.push_back(mk(K_WR, int'(HADDR / 4), 4'(mask), stim_wdata));
            end else begin
                pend.push_back(mk(K_RD1, int'(HADDR / 4), 4'b0, 32'd0));
                pend.push_back(mk(K_RD2, int'(HADDR / 4), 4'b0, 32'd0));
            end
        end
        if (pend.size() > 0) exp_cur = pend.pop_front();
        else                 exp_cur = mk(K_IDLE, 0, 4'b0, 32'd0);
        if (exp_cur.kind == K_RD2) begin
            exp_cur.hrdata = ref_mem[exp_cur.a];
            last_rd        = exp_cur.hrdata;
        end else begin
            exp_cur.hrdata = last_rd;
        end
        if (exp_cur.kind != K_IDLE) dp_cycles++;
        HREADY = !(exp_cur.kind inside {K_RD1, K_ERR1});
        HWDATA = (exp_cur.kind == K_WR) ? exp_cur.wdata : $urandom();
    endfunction

    // ---------------- per-cycle compare ----------------
    logic        chk_en = 1'b0;
    int          err_seen;
    int          cs_seen;
    logic [3:0]  seen_bwe;
    logic [31:0] rd_hist[$];

    always @(negedge HCLK) begin
        if (chk_en) begin
            check("hreadyout", 32'(HREADYOUT), 32'(!(exp_cur.kind inside {K_RD1, K_ERR1})));
            check("hresp", 32'(HRESP), (exp_cur.kind inside {K_ERR1, K_ERR2}) ? 32'd1 : 32'd0);
            check("sram_cs", 32'(SRAM_CS), 32'(exp_cur.kind inside {K_WR, K_RD1}));
            check("hrdata", HRDATA, exp_cur.hrdata);
            if (exp_cur.kind inside {K_WR, K_RD1}) begin
                check("sram_a", 32'(SRAM_A), 32'(exp_cur.a));
                check("sram_we", 32'(SRAM_WE), 32'(exp_cur.kind == K_WR));
            end
            if (exp_cur.kind == K_WR) begin
                check("sram_bwe", 32'(SRAM_BWE), 32'(exp_cur.bwe));
                check("sram_di", SRAM_DI, exp_cur.wdata);
            end
            if (HRESP == 2'b01) err_seen++;
            if (SRAM_CS) cs_seen++;
            if (SRAM_CS && SRAM_WE) seen_bwe = SRAM_BWE;
            if (exp_cur.kind == K_RD2) rd_hist.push_back(HRDATA);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
        model_update();
    endtask

    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic was_ready;
        int   n = 0;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
        HBURST = 3'($urandom_range(7));
        stim_wdata = wdata;
        do begin
            was_ready = HREADY;
            tick();
            n++;
        end while (!was_ready && n < 8);
        if (!was_ready) bound_expired("issue_wait");
    endtask

    task automatic settle();
        int n = 0;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        while (exp_cur.kind != K_IDLE && n < 10) begin
            tick();
            n++;
        end
        if (exp_cur.kind != K_IDLE) bound_expired("settle_wait");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < MW; i++) begin
            sram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
        SRAM_DO  = 32'd0;
        HRESETn  = 1'b0;
        exp_cur  = mk(K_IDLE, 0, 4'b0, 32'd0);
        last_rd  = 32'd0;
        dp_cycles = 0;

        // Reset with random bus activity: outputs stay at their reset values.
        for (int c = 0; c < 3; c++) begin
            @(posedge HCLK); #1;
            HSEL = 1'($urandom()); HADDR = $urandom(); HTRANS = 2'($urandom());
            HWRITE = 1'($urandom()); HSIZE = 3'($urandom()); HBURST = 3'($urandom());
            HWDATA = $urandom(); HREADY = 1'($urandom());
            @(negedge HCLK);
            check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
            check("rst_hresp", 32'(HRESP), 32'd0);
            check("rst_hrdata", HRDATA, 32'd0);
            check("rst_sram_cs", 32'(SRAM_CS), 32'd0);
        end
        check("rst_sram_we", 32'(SRAM_WE), 32'd0);
        check("rst_sram_bwe", 32'(SRAM_BWE), 32'd0);
        check("rst_sram_a", 32'(SRAM_A), 32'd0);

        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'd0;
        HREADY = 1'b1;
        HRESETn = 1'b1;
        chk_en = 1'b1;
        tick(); tick();

        // Word write then read of the same address.
        issue(1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
        settle();
        check("word_bwe", 32'(seen_bwe), 32'h0000_000F);
        check("word_rd", rd_hist[rd_hist.size()-1], 32'hDEAD_BEEF);

        // Sub-word writes with lanes unshifted on HWDATA, then word readback.
        issue(1'b1, 2'b10, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_1100);
        settle();
        check("byte_bwe", 32'(seen_bwe), 32'h0000_0002);
        issue(1'b1, 2'b10, 1'b1, 3'b001, 32'h0000_0022, 32'hABCD_0000);
        settle();
        check("half_bwe", 32'(seen_bwe), 32'h0000_000C);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0020, 32'd0);
        settle();
        check("merge_rd", rd_hist[rd_hist.size()-1], 32'hABCD_1108);

        // Back-to-back write, read-after-write, read with no idle gaps.
        rd_hist.delete();
        dp_cycles = 0;
        issue(1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
        issue(1'b1, 2'b11, 1'b0, 3'b010, 32'h0000_0044, 32'd0);
        settle();
        check("b2b_cycles", 32'(dp_cycles), 32'd5);
        check("b2b_raw", rd_hist[0], 32'h1234_5678);
        check("b2b_rd2", rd_hist[1], 32'h5A5A_0011);

        // Illegal transfers: misaligned, past the top, oversize.
        err_seen = 0; cs_seen = 0;
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0002, 32'd0);
        settle();
        check("err_misalign_resp", 32'(err_seen), 32'd2);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'(MW * 4), 32'd0);
        settle();
        check("err_range_resp", 32'(err_seen), 32'd4);
        issue(1'b1, 2'b10, 1'b1, 3'b011, 32'h0000_0000, 32'hFFFF_FFFF);
        settle();
        check("err_size_resp", 32'(err_seen), 32'd6);
        check("err_no_cs", 32'(cs_seen), 32'd0);

        // Last legal word is accepted.
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'(MW * 4 - 4), 32'd0);
        settle();
        check("top_word_rd", rd_hist[rd_hist.size()-1], init_word(MW - 1));

        // IDLE, BUSY and deselected NONSEQ never touch the SRAM.
        err_seen = 0; cs_seen = 0;
        issue(1'b1, 2'b00, 1'b1, 3'b010, 32'h0000_0050, 32'h1111_1111);
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0050, 32'd0);
        issue(1'b0, 2'b10, 1'b1, 3'b010, 32'h0000_0050, 32'h2222_2222);
        settle();
        tick();
        check("noxfer_cs", 32'(cs_seen), 32'd0);
        check("noxfer_err", 32'(err_seen), 32'd0);

        // Reset in the middle of a read wait state.
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
        HSEL = 1'b0; HTRANS = 2'b00;
        chk_en = 1'b0;
        #3 HRESETn = 1'b0;
        #1;
        check("rst_rd1_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_rd1_hresp", 32'(HRESP), 32'd0);
        check("rst_rd1_cs", 32'(SRAM_CS), 32'd0);
        check("rst_rd1_hrdata", HRDATA, 32'd0);
        tick();
        HRESETn = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        check("post_rst_hrdata", HRDATA, 32'd0);

        // Normal operation after the abort.
        issue(1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D);
        issue(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0080, 32'd0);
        settle();
        check("post_rst_rd", rd_hist[rd_hist.size()-1], 32'hCAFE_F00D);

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder that bridges the system AHB bus to a single-port synchronous SRAM macro.
- It sits behind the address decoder. Its HREADYOUT/HRESP/HRDATA feed one slave slot of the slave-to-master return mux, and the muxed bus HREADY comes back in.
- Writes complete with zero wait states; reads take one wait state.
- Illegal transfers get the two-cycle AHB ERROR response.

Parameters:
- MEM_WORDS, 16384, SRAM depth in 32-bit words. Byte range is MEM_WORDS*4. Must be a power of two.
- AW, $clog2(MEM_WORDS), SRAM word-address width. Localparam, derived, not overridable.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select from the decoder
- HADDR  in  32  address-phase address
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 byte, 001 halfword, 010 word
- HBURST  in  3  burst type. Ignored; each beat is handled independently.
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  muxed bus ready
- HRDATA  out  32  read data
- HREADYOUT  out  1  this slave's ready
- HRESP  out  2  00 OKAY, 01 ERROR
- SRAM_CS  out  1  SRAM chip select, active high
- SRAM_WE  out  1  1 = write cycle
- SRAM_BWE  out  4  byte write enables; bit n enables HWDATA[8n+7:8n]
- SRAM_A  out  AW  SRAM word address
- SRAM_DI  out  32  SRAM write data
- SRAM_DO  in  32  SRAM read data, valid the cycle after a CS-read

Behaviour:
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, SRAM_CS=0, SRAM_WE=0, SRAM_BWE=0, SRAM_A=0, state=IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. No SRAM write occurs in that cycle.
- Address-phase sample: occurs at a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. The sample registers addr, size, write and the legality result.
- A transfer is legal only if all three hold:
  - HSIZE<=010.
  - It is aligned: halfword needs HADDR[0]=0; word needs HADDR[1:0]=00.
  - HADDR < MEM_WORDS*4.
- No sample, or HTRANS IDLE/BUSY, means the next state is IDLE (zero-wait OKAY). HSEL=0 likewise gives IDLE.
- States, with outputs in each:
  - IDLE: HREADYOUT=1, HRESP=OKAY, SRAM idle.
  - WR: SRAM_CS=1, SRAM_WE=1, SRAM_A=addr[AW+1:2], SRAM_DI=HWDATA (combinational, lanes unshifted), BWE per byte-lane rule. HREADYOUT=1, OKAY. Single cycle.
  - RD1: SRAM_CS=1, SRAM_WE=0, SRAM_A=addr[AW+1:2], HREADYOUT=0, OKAY.
  - RD2: HRDATA=SRAM_DO (full 32-bit word, no lane masking), HREADYOUT=1, OKAY.
  - ERR1: HREADYOUT=0, HRESP=ERROR, no SRAM access.
  - ERR2: HREADYOUT=1, HRESP=ERROR, no SRAM access.
- Byte-lane rule:
  - byte: BWE = 0001 << addr[1:0].
  - halfword: 0011 if addr[1]=0, else 1100.
  - word: 1111.
- Transitions:
  - From IDLE, WR, RD2 or ERR2: a legal sample goes to WR or RD1 according to HWRITE; an illegal sample goes to ERR1; no sample goes to IDLE.
  - RD1 goes to RD2 and ERR1 goes to ERR2, unconditionally. No sampling occurs in these states because HREADY=0.
- Latency: write data phase is 1 cycle; read data phase is 2 cycles; error is 2 cycles.
- Pipelining rules:
  - A read address phase overlapping a WR data phase is accepted. The read's SRAM access happens in RD1, the cycle after the write, so the single port never conflicts.
  - A read from the address just written returns the new data.
- HRDATA is registered-through from SRAM_DO during RD2 only. Outside RD2 it holds the last read value.
- A transfer sampled during ERR2 is processed normally. The master is responsible for cancelling it with IDLE.
- HBURST is ignored, and bursts crossing the memory top error on the offending beat only.

Test Plan:
- Reset: hold HRESETn=0 with random inputs -> HREADYOUT=1, HRESP=00, HRDATA=0, SRAM_CS=0. Release -> state stays IDLE.
- Word write 0x0000_0010 <- 0xDEADBEEF, then read the same address -> write data-phase cycle shows SRAM_CS=1, WE=1, BWE=1111, A=4. Read has HREADYOUT=0 for 1 cycle, then HRDATA=0xDEADBEEF, OKAY.
- Byte writes 0x11 to address 0x21 and halfword 0xABCD to address 0x22 -> BWE=0010, then 1100. Word readback at 0x20 returns 0xABCD11xx, with byte 0 unchanged.
- Back-to-back NONSEQ write@0x40, read@0x40, read@0x44 with no idle gaps -> no SRAM port overlap. The first read returns the just-written data; the total is 1+2+2 data cycles.
- Misaligned word read at 0x0000_0002 -> ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), with no SRAM_CS. Same check for address MEM_WORDS*4 and for HSIZE=011.
- IDLE/BUSY transfers and HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, OKAY, SRAM_CS never asserted. Reset asserted during RD1 -> immediate IDLE outputs, no stale HRDATA update.
